stream_prefill_fifo: RTL and testbench

//  Single-clock FIFO for continuous frame streams whose valid flag rides in the data word (din[EN_BIT]).

---
 rtl/stream_prefill_fifo.sv | 266 ++++++++++++++++++++++++++
 tb/tb_stream_prefill_fifo.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_prefill_fifo.sv
// stream_prefill_fifo
// Single-clock FIFO for framed streams whose valid flag travels inside the
// data word (din[EN_BIT]). Each frame is held back until a runtime prefill
// threshold is met (or the whole frame, or a full FIFO, is present). It is
// then played out one word per cycle with no gaps. TAIL flag-0 words follow
// every frame in storage, so the reader can find frame ends without resetting
// the pointers between frames.
//
// Ports
//   CLK      clock, all logic on posedge
//   RST_X    asynchronous active-low reset
//   FRST     synchronous flush (pointers, counters, output register, FSM)
//   clr_err  synchronous clear of the sticky ovf/udf flags
//   wen      qualifies din
//   din      input word; din[EN_BIT] is the in-band valid flag
//   rd_thr   prefill threshold in words (0 acts as 1, values above DEPTH act as DEPTH)
//   dot      output word; dot[EN_BIT] mirrors dvalid
//   dvalid   dot carries a valid frame word
//   level    number of stored words, 0..DEPTH
//   busy     read FSM is not idle
//   ovf      sticky: a word was dropped because the FIFO was full
//   udf      sticky: the FIFO ran empty in the middle of a frame
module stream_prefill_fifo #(
    parameter int DW        = 27,
    parameter int DEPTH_LOG = 8,
    parameter int EN_BIT    = 25,
    parameter int TAIL      = 2
) (
    input  logic                 CLK,
    input  logic                 RST_X,
    input  logic                 FRST,
    input  logic                 clr_err,
    input  logic                 wen,
    input  logic [DW-1:0]        din,
    input  logic [DEPTH_LOG:0]   rd_thr,
    output logic [DW-1:0]        dot,
    output logic                 dvalid,
    output logic [DEPTH_LOG:0]   level,
    output logic                 busy,
    output logic                 ovf,
    output logic                 udf
);

    localparam int unsigned        DEPTH   = 32'd1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] DEPTH_V = {1'b1, {DEPTH_LOG{1'b0}}};
    localparam logic [DEPTH_LOG:0] ONE_V   = {{DEPTH_LOG{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG:0] ZERO_V  = {(DEPTH_LOG+1){1'b0}};
    localparam logic [3:0]         TAIL_V  = 4'(TAIL);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARMUP = 3'd1,
        ST_PRIME  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    logic [DW-1:0]        mem_r [DEPTH];
    logic [DEPTH_LOG:0]   wr_ptr_r;
    logic [DEPTH_LOG:0]   rd_ptr_r;
    logic [DEPTH_LOG:0]   level_r;
    logic [DEPTH_LOG:0]   term_cnt_r;
    logic [3:0]           tail_cnt_r;
    logic [DW-1:0]        dot_r;
    logic                 dvalid_r;
    logic                 busy_r;
    logic                 ovf_r;
    logic                 udf_r;
    state_t               state_r;

    logic                 enq_s;
    logic                 acc_s;
    logic                 deq_s;
    logic                 room_s;
    logic [DW-1:0]        head_s;
    logic [DEPTH_LOG:0]   thr_eff_s;
    state_t               state_nxt_s;
    logic [DW-1:0]        dot_nxt_s;
    logic                 udf_hit_s;
    logic                 term_inc_s;
    logic                 term_dec_s;
    logic [DW-1:0]        dot_s;

    // Flag-0 words are only stored while a frame still owes terminators;
    // a flush suppresses every write.
    assign enq_s      = wen & ~FRST & (din[EN_BIT] | (tail_cnt_r != 4'd0));
    assign room_s     = (level_r != DEPTH_V);
    // A full FIFO still accepts when the reader frees a slot in the same cycle.
    assign acc_s      = enq_s & (room_s | deq_s);
    assign head_s     = mem_r[rd_ptr_r[DEPTH_LOG-1:0]];
    assign term_inc_s = acc_s & ~din[EN_BIT];
    assign term_dec_s = deq_s & ~head_s[EN_BIT];

    // Clamp the prefill threshold into 1..DEPTH.
    always_comb begin
        thr_eff_s = rd_thr;
        if (rd_thr == ZERO_V) begin
            thr_eff_s = ONE_V;
        end else if (rd_thr > DEPTH_V) begin
            thr_eff_s = DEPTH_V;
        end else begin
            thr_eff_s = rd_thr;
        end
    end

    // Read FSM next-state, dequeue decision and next output word.
    always_comb begin
        state_nxt_s = state_r;
        dot_nxt_s   = dot_r;
        deq_s       = 1'b0;
        udf_hit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // No dequeue here, so acceptance only needs free room.
                if (enq_s && room_s) begin
                    state_nxt_s = ST_WARMUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WARMUP: begin
                // A stored terminator means the whole (short) frame is in.
                if ((level_r >= thr_eff_s) || (term_cnt_r != ZERO_V) || (level_r == DEPTH_V)) begin
                    state_nxt_s = ST_PRIME;
                end else begin
                    state_nxt_s = ST_WARMUP;
                end
            end
            ST_PRIME: begin
                deq_s       = 1'b1;
                dot_nxt_s   = head_s;
                state_nxt_s = ST_STREAM;
            end
            ST_STREAM: begin
                if (dot_r[EN_BIT]) begin
                    if (level_r != ZERO_V) begin
                        deq_s       = 1'b1;
                        dot_nxt_s   = head_s;
                        state_nxt_s = ST_STREAM;
                    end else begin
                        // Producer fell behind mid-frame: abandon the frame.
                        udf_hit_s         = 1'b1;
                        dot_nxt_s[EN_BIT] = 1'b0;
                        state_nxt_s       = ST_DRAIN;
                    end
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Discard leftover terminators until the next frame's head.
                if (level_r == ZERO_V) begin
                    state_nxt_s = ST_IDLE;
                end else if (head_s[EN_BIT]) begin
                    state_nxt_s = ST_WARMUP;
                end else begin
                    deq_s       = 1'b1;
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Storage array; contents are never reset and only read below level.
    always_ff @(posedge CLK) begin
        if (acc_s) begin
            mem_r[wr_ptr_r[DEPTH_LOG-1:0]] <= din;
        end
    end

    // Pointers, occupancy and frame bookkeeping counters.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            wr_ptr_r   <= ZERO_V;
            rd_ptr_r   <= ZERO_V;
            level_r    <= ZERO_V;
            term_cnt_r <= ZERO_V;
            tail_cnt_r <= 4'd0;
        end else if (FRST) begin
            wr_ptr_r   <= ZERO_V;
            rd_ptr_r   <= ZERO_V;
            level_r    <= ZERO_V;
            term_cnt_r <= ZERO_V;
            tail_cnt_r <= 4'd0;
        end else begin
            if (acc_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_V;
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_V;
            end
            case ({acc_s, deq_s})
                2'b10:   level_r <= level_r + ONE_V;
                2'b01:   level_r <= level_r - ONE_V;
                default: level_r <= level_r;
            endcase
            case ({term_inc_s, term_dec_s})
                2'b10:   term_cnt_r <= term_cnt_r + ONE_V;
                2'b01:   term_cnt_r <= term_cnt_r - ONE_V;
                default: term_cnt_r <= term_cnt_r;
            endcase
            // Terminator budget follows the producer even when a word is dropped.
            if (wen && din[EN_BIT]) begin
                tail_cnt_r <= TAIL_V;
            end else if (wen && (tail_cnt_r != 4'd0)) begin
                tail_cnt_r <= tail_cnt_r - 4'd1;
            end
        end
    end

    // Read FSM state and registered output word/flags.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_r  <= ST_IDLE;
            dot_r    <= {DW{1'b0}};
            dvalid_r <= 1'b0;
            busy_r   <= 1'b0;
        end else if (FRST) begin
            state_r  <= ST_IDLE;
            dot_r    <= {DW{1'b0}};
            dvalid_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            dot_r    <= dot_nxt_s;
            dvalid_r <= (state_nxt_s == ST_STREAM) & dot_nxt_s[EN_BIT];
            busy_r   <= (state_nxt_s != ST_IDLE);
        end
    end

    // Sticky error flags; a set in the same cycle beats clr_err, flush keeps them.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (enq_s && !acc_s) begin
                ovf_r <= 1'b1;
            end else if (clr_err) begin
                ovf_r <= 1'b0;
            end
            if (udf_hit_s && !FRST) begin
                udf_r <= 1'b1;
            end else if (clr_err) begin
                udf_r <= 1'b0;
            end
        end
    end

    // Output word carries dvalid in the flag position.
    always_comb begin
        dot_s         = dot_r;
        dot_s[EN_BIT] = dvalid_r;
    end

    assign dot    = dot_s;
    assign dvalid = dvalid_r;
    assign level  = level_r;
    assign busy   = busy_r;
    assign ovf    = ovf_r;
    assign udf    = udf_r;

endmodule

// File: tb/tb_stream_prefill_fifo.sv
module tb_stream_prefill_fifo;
    localparam int DW   = 27;
    localparam int DL   = 8;
    localparam int EN   = 25;
    localparam int TAIL = 2;
    localparam int SDL  = 3;

    logic          CLK = 1'b0;
    logic          RST_X = 1'b0;
    logic          frst = 1'b0, clr = 1'b0, wen = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DL:0]   rd_thr = '0;
    logic [DW-1:0] dot;
    logic          dvalid, busy, ovf, udf;
    logic [DL:0]   level;

    logic          s_frst = 1'b0, s_clr = 1'b0, s_wen = 1'b0;
    logic [DW-1:0] s_din = '0;
    logic [SDL:0]  s_thr = '0;
    logic [DW-1:0] s_dot;
    logic          s_dvalid, s_busy, s_ovf, s_udf;
    logic [SDL:0]  s_level;

    stream_prefill_fifo dut (
        .CLK(CLK), .RST_X(RST_X), .FRST(frst), .clr_err(clr), .wen(wen), .din(din),
        .rd_thr(rd_thr), .dot(dot), .dvalid(dvalid), .level(level), .busy(busy),
        .ovf(ovf), .udf(udf));

    stream_prefill_fifo #(.DEPTH_LOG(SDL)) sdut (
        .CLK(CLK), .RST_X(RST_X), .FRST(s_frst), .clr_err(s_clr), .wen(s_wen), .din(s_din),
        .rd_thr(s_thr), .dot(s_dot), .dvalid(s_dvalid), .level(s_level), .busy(s_busy),
        .ovf(s_ovf), .udf(s_udf));

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: every flag-1 word accepted must come out, in order, once.
    logic [DW-1:0] sb[$];
    logic [DW-1:0] ssb[$];
    int  rises = 0;
    logic prev_dv = 1'b0;
    int  lat_start = 0, lat_exp = 0;
    bit  lat_wait = 1'b0;

    function automatic logic [DW-1:0] mk_word(input logic flag);
        logic [DW-1:0] w;
        w = DW'($urandom);
        w[EN] = flag;
        return w;
    endfunction

    always @(negedge CLK) begin
        if (RST_X) begin
            if (dvalid) begin
                if (sb.size() == 0) check_eq("extra_word", 32'(dvalid), 32'd0);
                else check_eq("data", 32'(dot), 32'(sb.pop_front()));
            end
            if (dvalid && !prev_dv) begin
                rises++;
                if (lat_wait) begin
                    check_eq("latency", 32'(cyc - lat_start), 32'(lat_exp));
                    lat_wait = 1'b0;
                end
            end
            prev_dv = dvalid;
            if (s_dvalid) begin
                if (ssb.size() == 0) check_eq("s_extra_word", 32'(s_dvalid), 32'd0);
                else check_eq("s_data", 32'(s_dot), 32'(ssb.pop_front()));
            end
        end else begin
            prev_dv = 1'b0;
        end
    end

    task automatic send_frame(input int len, input int junk, input bit track, input int lat);
        for (int i = 0; i < len; i++) begin
            @(negedge CLK);
            if (i == 0 && track) begin
                lat_start = cyc + 1;
                lat_exp   = lat;
                lat_wait  = 1'b1;
            end
            wen = 1'b1;
            din = mk_word(1'b1);
            sb.push_back(din);
        end
        for (int i = 0; i < TAIL; i++) begin
            @(negedge CLK);
            wen = 1'b1;
            din = mk_word(1'b0);
        end
        // Flag-0 words beyond the terminators must not be stored.
        for (int i = 0; i < junk; i++) begin
            @(negedge CLK);
            wen = 1'($urandom_range(0, 1));
            din = mk_word(1'b0);
        end
        @(negedge CLK);
        wen = 1'b0;
        din = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || level != 0 || sb.size() != 0) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_level"}, 32'(level), 32'd0);
        check_eq({tag, "_pending"}, 32'(sb.size()), 32'd0);
        check_eq({tag, "_lat_seen"}, 32'(lat_wait), 32'd0);
    endtask

    function automatic int exp_lat(input int thr, input int len);
        int t;
        t = (thr == 0) ? 1 : ((thr > 256) ? 256 : thr);
        return ((t < len + 1) ? t : len + 1) + 1;
    endfunction

    initial begin
        int r0, nfr, n;
        #1;
        check_eq("rst_dot", 32'(dot), 32'd0);
        check_eq("rst_dvalid", 32'(dvalid), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        check_eq("rst_udf", 32'(udf), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST_X = 1'b1;

        // Long frame with prefill of 4.
        rd_thr = 9'd4;
        send_frame(10, 0, 1'b1, exp_lat(4, 10));
        wait_idle("t1");

        // Short frame released by its terminator.
        rd_thr = 9'd8;
        send_frame(3, 0, 1'b1, exp_lat(8, 3));
        wait_idle("t2");
        check_eq("t2_udf", 32'(udf), 32'd0);

        // Two frames back to back.
        rd_thr = 9'd2;
        r0 = rises;
        send_frame(6, 0, 1'b1, exp_lat(2, 6));
        send_frame(6, 0, 1'b0, 0);
        wait_idle("t3");
        check_eq("t3_frames", 32'(rises - r0), 32'd2);

        // Randomized frames, thresholds, junk and back-to-back spacing.
        r0 = rises;
        nfr = 0;
        for (int f = 0; f < 25; f++) begin
            int len, junk, thr;
            len  = $urandom_range(1, 24);
            junk = $urandom_range(0, 3);
            if (f > 0 && $urandom_range(0, 2) == 0) begin
                send_frame(len, junk, 1'b0, 0);
            end else begin
                wait_idle("rnd");
                thr = $urandom_range(0, 300);
                rd_thr = 9'(thr);
                send_frame(len, junk, 1'b1, exp_lat(thr, len));
            end
            nfr++;
        end
        wait_idle("rnd_end");
        check_eq("rnd_frames", 32'(rises - r0), 32'(nfr));
        check_eq("rnd_ovf", 32'(ovf), 32'd0);
        check_eq("rnd_udf", 32'(udf), 32'd0);

        // Depth-8 instance: full FIFO forces PRIME; the word hitting full is dropped.
        s_thr = 4'd8;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (i == 8) begin
                check_eq("s_full_level", 32'(s_level), 32'd8);
                check_eq("s_ovf_before", 32'(s_ovf), 32'd0);
            end
            if (i == 9) check_eq("s_ovf_set", 32'(s_ovf), 32'd1);
            s_wen = 1'b1;
            s_din = mk_word(1'b1);
            if (i != 8) ssb.push_back(s_din);
        end
        for (int i = 0; i < TAIL; i++) begin
            @(negedge CLK);
            s_din = mk_word(1'b0);
        end
        @(negedge CLK);
        s_wen = 1'b0;
        n = 0;
        while ((s_busy || s_level != 0 || ssb.size() != 0) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check_eq("s_pending", 32'(ssb.size()), 32'd0);
        check_eq("s_idle_level", 32'(s_level), 32'd0);
        check_eq("s_ovf_kept", 32'(s_ovf), 32'd1);
        check_eq("s_udf", 32'(s_udf), 32'd0);
        s_clr = 1'b1;
        @(negedge CLK);
        s_clr = 1'b0;
        check_eq("s_ovf_clr", 32'(s_ovf), 32'd0);

        // Producer stall mid-frame causes underflow, then the frame resumes.
        rd_thr = 9'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            wen = 1'b1;
            din = mk_word(1'b1);
            sb.push_back(din);
        end
        @(negedge CLK);
        wen = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        send_frame(4, 0, 1'b0, 0);
        wait_idle("t5");
        check_eq("t5_udf", 32'(udf), 32'd1);
        check_eq("t5_ovf", 32'(ovf), 32'd0);

        // Flush while streaming with level 5.
        rd_thr = 9'd4;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            wen = 1'b1;
            din = mk_word(1'b1);
            sb.push_back(din);
        end
        @(negedge CLK);
        check_eq("t6_level5", 32'(level), 32'd5);
        check_eq("t6_streaming", 32'(dvalid), 32'd1);
        frst = 1'b1;
        din  = mk_word(1'b1);
        @(negedge CLK);
        frst = 1'b0;
        wen  = 1'b0;
        check_eq("t6_level", 32'(level), 32'd0);
        check_eq("t6_dvalid", 32'(dvalid), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_udf", 32'(udf), 32'd1);
        check_eq("t6_ovf", 32'(ovf), 32'd0);
        sb.delete();
        repeat (3) @(negedge CLK);
        check_eq("t6_still_idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a frame.
        rd_thr = 9'd1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            wen = 1'b1;
            din = mk_word(1'b1);
            sb.push_back(din);
        end
        @(negedge CLK);
        wen = 1'b0;
        RST_X = 1'b0;
        #1;
        check_eq("ar_dot", 32'(dot), 32'd0);
        check_eq("ar_dvalid", 32'(dvalid), 32'd0);
        check_eq("ar_level", 32'(level), 32'd0);
        check_eq("ar_busy", 32'(busy), 32'd0);
        check_eq("ar_ovf", 32'(ovf), 32'd0);
        check_eq("ar_udf", 32'(udf), 32'd0);
        sb.delete();
        @(negedge CLK);
        RST_X = 1'b1;
        repeat (2) @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
